// File: rtl/hawk_burst_wr_mngr.sv
`default_nettype none
// ============================================================================
// hawk_burst_wr_mngr : page-transfer write manager (N lines + metadata line),
// decoupled AW/W with bounded outstanding writes and B error tracking.
// Option macro: HAWK_WR_MNGR_DUMMY_DATA_EN. Revision 1.0
// ============================================================================
module hawk_burst_wr_mngr #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int LEN_W           = 7,
    parameter int LINES_PER_PAGE  = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MD_W            = 496
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                job_valid_i,
    output logic                job_ready_o,
    input  logic                job_mode_i,
    input  logic [ADDR_W-1:0]   job_addr_i,
    input  logic [LEN_W-1:0]    job_nlines_i,
    input  logic [ADDR_W-1:0]   job_md_addr_i,
    input  logic [MD_W-1:0]     job_md_data_i,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    input  logic [DATA_W-1:0]   src_data_i,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    input  logic                bvalid_i,
    input  logic [1:0]          bresp_i,
    output logic                bready_o,
    output logic                done_o,
    output logic                err_o,
    output logic                busy_o,
    output logic [2:0]          state_o
);
    localparam int                 STRB_W  = DATA_W / 8;
    localparam logic [STRB_W-1:0]  MD_STRB = {STRB_W{1'b1}} >> (STRB_W - MD_W / 8);
    localparam logic [3:0]         MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA    = 3'd1,
        S_DRAIN   = 3'd2,
        S_MD_ADDR = 3'd3,
        S_MD_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state;
    logic                mode;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   md_addr;
    logic [MD_W-1:0]     md_data;
    logic [LEN_W-1:0]    nlines;
    logic [LEN_W-1:0]    aw_idx;
    logic [LEN_W-1:0]    w_idx;
    logic [3:0]          outstanding;
    logic                md_aw_done;
    logic                md_w_done;

    logic                aw_fire, w_fire, b_fire, b_take;
    logic [3:0]          out_next;
    logic [LEN_W-1:0]    aw_idx_next, w_idx_next, w_loaded, job_n;
    logic                w_load_ok, w_load, job_accept;
    logic [DATA_W-1:0]   line_data;
    logic [ADDR_W-1:0]   job_base;

    assign aw_fire     = awvalid_o & awready_i;
    assign w_fire      = wvalid_o & wready_i;
    assign b_fire      = bvalid_i & bready_o;
    // A B beat with nothing outstanding is dropped rather than underflowing
    assign b_take      = b_fire && (outstanding != 4'd0);
    assign out_next    = outstanding + 4'(aw_fire) - 4'(b_take);
    assign aw_idx_next = aw_idx + LEN_W'(aw_fire);
    assign w_idx_next  = w_idx + LEN_W'(w_fire);
    assign w_loaded    = w_idx + LEN_W'(wvalid_o);
    assign w_load_ok   = (state == S_DATA) && (!wvalid_o || wready_i) && (w_loaded < aw_idx);
    assign job_accept  = job_valid_i && job_ready_o;
    assign job_n       = job_mode_i ? job_nlines_i : LEN_W'(LINES_PER_PAGE);
    assign job_base    = job_addr_i & ~ADDR_W'(64'h3F);

`ifdef HAWK_WR_MNGR_DUMMY_DATA_EN
    logic unused_src;
    assign unused_src  = ^{src_valid_i, src_data_i};
    assign src_ready_o = 1'b0;
    assign w_load      = w_load_ok;
    assign line_data   = mode ? {(DATA_W/16){16'h1234}} : {(DATA_W/16){16'hF0F0}};
`else
    assign src_ready_o = w_load_ok;
    assign w_load      = w_load_ok && src_valid_i;
    assign line_data   = src_data_i;
`endif

    assign busy_o   = (state != S_IDLE);
    assign bready_o = busy_o;
    assign done_o   = (state == S_DONE);
    assign state_o  = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            job_ready_o <= 1'b0;
            mode        <= 1'b0;
            base        <= '0;
            md_addr     <= '0;
            md_data     <= '0;
            nlines      <= '0;
            aw_idx      <= '0;
            w_idx       <= '0;
            outstanding <= '0;
            md_aw_done  <= 1'b0;
            md_w_done   <= 1'b0;
            awvalid_o   <= 1'b0;
            awaddr_o    <= '0;
            wvalid_o    <= 1'b0;
            wdata_o     <= '0;
            wstrb_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            outstanding <= out_next;
            aw_idx      <= aw_idx_next;
            w_idx       <= w_idx_next;
            if (b_fire && (bresp_i != 2'b00)) begin
                err_o <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    job_ready_o <= !job_accept;
                    if (job_accept) begin
                        mode        <= job_mode_i;
                        base        <= job_base;
                        md_addr     <= job_md_addr_i;
                        md_data     <= job_md_data_i;
                        nlines      <= job_n;
                        aw_idx      <= '0;
                        w_idx       <= '0;
                        outstanding <= '0;
                        md_aw_done  <= 1'b0;
                        md_w_done   <= 1'b0;
                        err_o       <= 1'b0;
                        awvalid_o   <= 1'b1;
                        if (job_n == '0) begin
                            awaddr_o <= job_md_addr_i;
                            wvalid_o <= 1'b1;
                            wdata_o  <= DATA_W'(job_md_data_i);
                            wstrb_o  <= MD_STRB;
                            state    <= S_MD_ADDR;
                        end else begin
                            awaddr_o <= job_base;
                            state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (!awvalid_o || aw_fire) begin
                        awvalid_o <= (aw_idx_next < nlines) && (out_next < MAX_OUT);
                        awaddr_o  <= base + (ADDR_W'(aw_idx_next) << 6);
                    end
                    if (w_load) begin
                        wvalid_o <= 1'b1;
                        wdata_o  <= line_data;
                        wstrb_o  <= '1;
                    end else if (w_fire) begin
                        wvalid_o <= 1'b0;
                    end
                    if (w_idx_next == nlines) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_next == 4'd0) begin
                        awvalid_o <= 1'b1;
                        awaddr_o  <= md_addr;
                        wvalid_o  <= 1'b1;
                        wdata_o   <= DATA_W'(md_data);
                        wstrb_o   <= MD_STRB;
                        state     <= S_MD_ADDR;
                    end
                end
                S_MD_ADDR: begin
                    if (aw_fire) begin
                        awvalid_o  <= 1'b0;
                        md_aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_o  <= 1'b0;
                        md_w_done <= 1'b1;
                    end
                    if ((md_aw_done || aw_fire) && (md_w_done || w_fire)) begin
                        state <= S_MD_WAIT;
                    end
                end
                S_MD_WAIT: begin
                    if (out_next == 4'd0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    job_ready_o <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hawk_burst_wr_mngr.sv
`default_nettype none
// ============================================================================
// tb_hawk_burst_wr_mngr : randomized bench with a queue-based reference model.
// Revision 1.0
// ============================================================================
module tb_hawk_burst_wr_mngr;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int LEN_W  = 7;
    localparam int LPP    = 64;
    localparam int MAXO   = 4;
    localparam int MD_W   = 496;
    localparam int SW     = DATA_W / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              job_valid_i, job_ready_o, job_mode_i;
    logic [ADDR_W-1:0] job_addr_i, job_md_addr_i;
    logic [LEN_W-1:0]  job_nlines_i;
    logic [MD_W-1:0]   job_md_data_i;
    logic              src_valid_i, src_ready_o;
    logic [DATA_W-1:0] src_data_i;
    logic              awvalid_o, awready_i;
    logic [ADDR_W-1:0] awaddr_o;
    logic              wvalid_o, wready_i;
    logic [DATA_W-1:0] wdata_o;
    logic [SW-1:0]     wstrb_o;
    logic              bvalid_i, bready_o;
    logic [1:0]        bresp_i;
    logic              done_o, err_o, busy_o;
    logic [2:0]        state_o;

    hawk_burst_wr_mngr #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .LINES_PER_PAGE(LPP),
        .MAX_OUTSTANDING(MAXO), .MD_W(MD_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_mode_i(job_mode_i),
        .job_addr_i(job_addr_i), .job_nlines_i(job_nlines_i),
        .job_md_addr_i(job_md_addr_i), .job_md_data_i(job_md_data_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit prev_err = 1'b0;

    logic [ADDR_W-1:0] exp_aw[$];
    logic [DATA_W-1:0] exp_w[$];
    logic [SW-1:0]     exp_s[$];
    int                pend[$];

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_wide();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        awready_i   = 1'b0;
        wready_i    = 1'b0;
        src_valid_i = 1'b0;
        src_data_i  = '0;
        bvalid_i    = 1'b0;
        bresp_i     = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_awvalid"}, awvalid_o, 0);
        check_eq({tag, "_wvalid"}, wvalid_o, 0);
        check_eq({tag, "_ctl"}, {job_ready_o, src_ready_o, bready_o, done_o, err_o, busy_o}, 0);
        check_eq({tag, "_state"}, state_o, 0);
    endtask

    // abort_w > 0: apply reset once that many W beats have completed
    task automatic run_job(input bit mode, input int nl, input logic [ADDR_W-1:0] addr,
                           input logic [ADDR_W-1:0] mda, input int rdy_pct,
                           input int lat_min, input int lat_max, input int hold_cycles,
                           input int err_b, input int abort_w);
        logic [DATA_W-1:0] lines[$];
        logic [DATA_W-1:0] md_full;
        logic [DATA_W-1:0] prev_wdata;
        logic [ADDR_W-1:0] prev_awaddr;
        logic [15:0]       pat;
        int n, aw_n, w_n, b_n, src_idx, outst, done_cnt, t, hold_end, err_cyc;
        bit exp_err, prev_aw_stall, prev_w_stall;

        n = mode ? nl : LPP;
        md_full = rand_wide();
        md_full[DATA_W-1:MD_W] = '0;
        pat = mode ? 16'h1234 : 16'hF0F0;
        exp_aw.delete(); exp_w.delete(); exp_s.delete(); pend.delete();
        for (int k = 0; k < n; k++) begin
            lines.push_back(rand_wide());
            exp_aw.push_back((addr & ~64'h3F) + 64'(64 * k));
`ifdef HAWK_WR_MNGR_DUMMY_DATA_EN
            exp_w.push_back({(DATA_W/16){pat}});
`else
            exp_w.push_back(lines[k]);
`endif
            exp_s.push_back({SW{1'b1}});
        end
        exp_aw.push_back(mda);
        exp_w.push_back(md_full);
        exp_s.push_back(64'h3FFF_FFFF_FFFF_FFFF);

        aw_n = 0; w_n = 0; b_n = 0; src_idx = 0; outst = 0; done_cnt = 0;
        exp_err = 1'b0; prev_aw_stall = 1'b0; prev_w_stall = 1'b0; err_cyc = 0;
        prev_awaddr = '0; prev_wdata = '0;

        @(negedge clk_i);
        idle_inputs();
        t = 0;
        while (!job_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("job_ready_idle", job_ready_o, 1);
        check_eq("err_held_until_accept", err_o, prev_err);
        job_valid_i   = 1'b1;
        job_mode_i    = mode;
        job_addr_i    = addr;
        job_nlines_i  = LEN_W'(nl);
        job_md_addr_i = mda;
        job_md_data_i = md_full[MD_W-1:0];
        @(posedge clk_i);
        @(negedge clk_i);
        job_valid_i = 1'b0;
        check_eq("err_cleared_on_accept", err_o, 0);
        check_eq("busy_after_accept", busy_o, 1);
        if (n > 0) check_eq("first_aw_t_plus_1", {awvalid_o, awaddr_o}, {1'b1, exp_aw[0]});
        hold_end = cyc + hold_cycles;

        for (int step = 0; step < 4000; step++) begin
            if (prev_aw_stall) check_eq("aw_stable", {awvalid_o, awaddr_o}, {1'b1, prev_awaddr});
            if (prev_w_stall) check_eq("w_stable", {wvalid_o, wdata_o}, {1'b1, prev_wdata});
            awready_i   = ($urandom_range(0, 99) < rdy_pct);
            wready_i    = ($urandom_range(0, 99) < rdy_pct);
            src_valid_i = ($urandom_range(0, 99) < rdy_pct);
            src_data_i  = (src_idx < n) ? lines[src_idx] : '0;
            if (pend.size() > 0 && pend[0] <= cyc && cyc >= hold_end) begin
                bvalid_i = 1'b1;
                bresp_i  = (b_n == err_b) ? 2'b10 : 2'b00;
            end else begin
                bvalid_i = 1'b0;
                bresp_i  = 2'b00;
            end
            #1;
            if (hold_cycles > 0 && cyc == hold_end - 1) check_eq("aw_stall_at_max", aw_n, MAXO);
            if (exp_err && cyc > err_cyc) check_eq("err_sticky", err_o, 1);
`ifdef HAWK_WR_MNGR_DUMMY_DATA_EN
            if (src_ready_o) check_eq("src_ready_tied_low", src_ready_o, 0);
`endif
            if (awvalid_o && awready_i) begin
                if (aw_n < exp_aw.size()) check_eq("aw_addr", awaddr_o, exp_aw[aw_n]);
                else check_eq("aw_count_overrun", aw_n, exp_aw.size() - 1);
                aw_n++;
                outst++;
                check_eq("outstanding_le_max", outst <= MAXO, 1);
                pend.push_back(cyc + $urandom_range(lat_min, lat_max));
            end
            if (wvalid_o && wready_i) begin
                check_eq("w_after_aw", w_n < aw_n, 1);
                if (w_n < exp_w.size()) begin
                    check_eq("w_data", wdata_o, exp_w[w_n]);
                    check_eq("w_strb", wstrb_o, exp_s[w_n]);
                end else check_eq("w_count_overrun", w_n, exp_w.size() - 1);
                w_n++;
            end
            if (src_valid_i && src_ready_o) begin
                check_eq("src_not_overrun", src_idx < n, 1);
                src_idx++;
            end
            if (bvalid_i && bready_o) begin
                void'(pend.pop_front());
                b_n++;
                outst--;
                if (bresp_i != 2'b00 && !exp_err) begin
                    exp_err = 1'b1;
                    err_cyc = cyc;
                end
            end
            if (done_o) done_cnt++;
            if (abort_w > 0 && w_n >= abort_w) begin
                rst_ni = 1'b0;
                #1;
                check_reset_outputs("reset_mid_job");
                idle_inputs();
                pend.delete();
                @(posedge clk_i);
                @(posedge clk_i);
                @(negedge clk_i);
                rst_ni   = 1'b1;
                prev_err = 1'b0;
                return;
            end
            if (done_o) break;
            prev_aw_stall = awvalid_o && !awready_i;
            prev_awaddr   = awaddr_o;
            prev_w_stall  = wvalid_o && !wready_i;
            prev_wdata    = wdata_o;
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
        end

        check_eq("done_seen_once", done_cnt, 1);
        check_eq("aw_total", aw_n, n + 1);
        check_eq("w_total", w_n, n + 1);
`ifndef HAWK_WR_MNGR_DUMMY_DATA_EN
        check_eq("src_total", src_idx, n);
`endif
        check_eq("err_at_done", err_o, exp_err);
        check_eq("model_outstanding_zero", outst, 0);
        idle_inputs();
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        check_eq("done_one_cycle", done_o, 0);
        check_eq("job_ready_after_done", job_ready_o, 1);
        check_eq("idle_after_done", {busy_o, state_o}, 0);
        check_eq("err_kept_after_done", err_o, exp_err);
        prev_err = exp_err;
    endtask

    initial begin
        rst_ni        = 1'b0;
        job_valid_i   = 1'b0;
        job_mode_i    = 1'b0;
        job_addr_i    = '0;
        job_nlines_i  = '0;
        job_md_addr_i = '0;
        job_md_data_i = '0;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;

        run_job(1'b1, 17, 64'h1000, 64'h8000_0000, 100, 2, 2, 0, -1, 0);
        run_job(1'b0, 0, 64'h20_0000, 64'h20_4000, 50, 1, 4, 40, -1, 0);
        run_job(1'b1, 0, 64'h3000, 64'h3FC0, 100, 1, 2, 0, -1, 0);
        run_job(1'b1, 8, 64'h4000, 64'h5000, 100, 1, 3, 0, 3, 0);
        run_job(1'b0, 0, 64'h6000, 64'h7000, 100, 1, 2, 0, -1, 5);
        run_job(1'b1, 6, 64'h6000, 64'h7040, 100, 1, 2, 0, -1, 0);
        for (int r = 0; r < 6; r++) begin
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 40),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(30, 100), 1, $urandom_range(1, 6), 0,
                    $urandom_range(0, 9) - 2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
